// File: rtl/fc8_cart_pkg.sv
// Shared constants and FSM state type for the FC8 cartridge bank mapper.
package fc8_cart_pkg;

    localparam logic [15:0] WIN_LO_BASE      = 16'h8000;
    localparam logic [15:0] WIN_HI_BASE      = 16'hC000;
    localparam int unsigned BANK_AW          = 14;
    localparam logic [7:0]  DEFAULT_BYTE_DEF = 8'hEA;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StData
    } cart_state_e;

endpackage

// File: rtl/fc8_cart_rom_mem.sv
// Cartridge ROM image store: one synchronous write port, one synchronous
// read port; a same-cycle read of the written byte returns the old contents.
module fc8_cart_rom_mem
    import fc8_cart_pkg::*;
#(
    parameter int unsigned AW = BANK_AW + 3
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [2**AW];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fc8_cart_mapper.sv
// FC8 cartridge mapper: switchable 16 KiB bank at $8000, fixed last bank at
// $C000, bank-select register, and a read FSM with configurable wait states.
module fc8_cart_mapper
    import fc8_cart_pkg::*;
#(
    parameter int unsigned NUM_BANKS       = 8,
    parameter int unsigned WAIT_STATES     = 0,
    parameter logic [15:0] MAPPER_REG_ADDR = 16'h00FF,
    parameter logic [7:0]  DEFAULT_BYTE    = DEFAULT_BYTE_DEF,
    localparam int unsigned BW             = $clog2(NUM_BANKS)
) (
    input  logic            clk_20mhz,
    input  logic            rst_n,
    input  logic [15:0]     cpu_addr,
    input  logic [7:0]      cpu_wdata,
    input  logic            cpu_we,
    input  logic            cpu_re,
    input  logic            load_en,
    input  logic [BW+13:0]  load_addr,
    input  logic [7:0]      load_data,
    output logic [7:0]      cart_rom_data,
    output logic            cart_ready,
    output logic [BW-1:0]   bank_sel,
    output logic [15:0]     rd_count
);

    localparam int unsigned AW        = BW + BANK_AW;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES - 1);

    cart_state_e   state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [BW-1:0] bank_sel_q, bank_sel_d;
    logic [15:0]   rd_count_q, rd_count_d;
    logic          win_q, win_d;

    logic          accept;
    logic          in_win;
    logic [BW-1:0] rd_bank;
    logic [7:0]    rom_rdata;

    assign accept  = cpu_re && (state_q != StWait);
    assign in_win  = cpu_addr >= WIN_LO_BASE;
    // Bank is resolved from the pre-write register, so a coincident mapper write is not seen.
    assign rd_bank = (cpu_addr >= WIN_HI_BASE) ? BW'(NUM_BANKS - 1) : bank_sel_q;

    // The read register inside the ROM captures the byte at acceptance, so the
    // pending read is immune to later address or bank changes.
    fc8_cart_rom_mem #(
        .AW(AW)
    ) u_rom (
        .clk_i   (clk_20mhz),
        .we_i    (load_en),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .re_i    (accept && in_win),
        .raddr_i ({rd_bank, cpu_addr[BANK_AW-1:0]}),
        .rdata_o (rom_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bank_sel_d = bank_sel_q;
        rd_count_d = rd_count_q;
        win_d      = win_q;

        if (cpu_we && (cpu_addr == MAPPER_REG_ADDR)) begin
            bank_sel_d = BW'(cpu_wdata % NUM_BANKS);
        end

        if (state_q == StWait) begin
            if (wait_cnt_q == 4'd0) begin
                state_d = StData;
            end else begin
                wait_cnt_d = wait_cnt_q - 4'd1;
            end
        end

        if (accept) begin
            win_d = in_win;
            if (in_win && (rd_count_q != 16'hFFFF)) begin
                rd_count_d = rd_count_q + 16'd1;
            end
            if (WAIT_STATES == 0) begin
                state_d = StData;
            end else begin
                state_d    = StWait;
                wait_cnt_d = WAIT_INIT;
            end
        end
    end

    always_ff @(posedge clk_20mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            bank_sel_q <= '0;
            rd_count_q <= 16'd0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bank_sel_q <= bank_sel_d;
            rd_count_q <= rd_count_d;
            win_q      <= win_d;
        end
    end

    assign cart_ready    = (state_q != StWait);
    assign cart_rom_data = ((state_q == StData) && win_q) ? rom_rdata : DEFAULT_BYTE;
    assign bank_sel      = bank_sel_q;
    assign rd_count      = rd_count_q;

endmodule
